// File: rtl/apb_pkg.sv
// Shared APB slave types and defaults: FSM state encoding, bus widths, wait-count limits.
package apb_pkg;

    localparam int APB_ADDR_W   = 8;
    localparam int APB_DATA_W   = 8;
    localparam int APB_WAIT_MAX = 15;
    localparam int APB_CNT_W    = $clog2(APB_WAIT_MAX + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between the master and a single selected slave.
interface apb_wait_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W
) ();

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_mem.sv
// Register file: DEPTH words, async clear, synchronous write, registered read port.
// Read data loads one edge after i_rd_ld and holds until cleared; no backpressure.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int IDX_W      = 6
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  i_wr_vld,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic                  i_rd_ld,
    input  logic                  i_rd_zero,
    input  logic                  i_rd_clr,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_dat
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_dat;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_vld) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    // Zero-load covers writes and out-of-range reads so PRDATA is 0 in those ready cycles.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rd_dat <= '0;
        end else if (i_rd_ld) begin
            r_rd_dat <= i_rd_zero ? '0 : r_mem[i_rd_idx];
        end else if (i_rd_clr) begin
            r_rd_dat <= '0;
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/apb_wait_slave.sv
// APB register-file slave inserting WAIT_CYCLES wait states; out-of-range addresses answer PSLVERR.
// PREADY is high WAIT_CYCLES cycles after the first access cycle; all outputs are registered.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_wait_slave_if.slave     apb
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [APB_CNT_W-1:0] cnt_t;

    localparam cnt_t WAIT_LD = cnt_t'(WAIT_CYCLES);
    localparam logic RDY_LD  = (WAIT_CYCLES == 0);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    cnt_t                  r_cnt;
    cnt_t                  w_cnt_nxt;
    logic                  r_rdy;
    logic                  w_rdy_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_oor;
    logic [DATA_WIDTH-1:0] r_wdat;

    logic                  w_in_oor;
    logic                  w_take;
    logic                  w_wr_vld;
    logic                  w_rd_ld;
    logic                  w_rd_zero;
    logic                  w_rd_clr;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_dat;

    // Extra top bit keeps DEPTH == 2**ADDR_WIDTH representable in the compare.
    assign w_in_oor = ({1'b0, apb.PADDR} >= (ADDR_WIDTH + 1)'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy_nxt   = r_rdy;
        w_err_nxt   = r_err;
        w_take      = 1'b0;
        w_wr_vld    = 1'b0;
        w_rd_ld     = 1'b0;
        w_rd_zero   = 1'b1;
        w_rd_clr    = 1'b0;
        w_rd_idx    = r_idx;

        case (r_state)
            IDLE: begin
                w_take = apb.PSEL && !apb.PENABLE;
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_rdy_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rd_clr    = 1'b1;
                end else if (!apb.PENABLE) begin
                    w_take = 1'b1;
                end else if (r_rdy) begin
                    w_state_nxt = IDLE;
                    w_wr_vld    = r_write && !r_oor;
                    w_rdy_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rd_clr    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - cnt_t'(1);
                    if (r_cnt == cnt_t'(1)) begin
                        w_rdy_nxt = 1'b1;
                        w_err_nxt = r_oor;
                        w_rd_ld   = 1'b1;
                        w_rd_zero = r_write || r_oor;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A setup from either state restarts the access; a pending one is dropped unwritten.
        if (w_take) begin
            w_state_nxt = ACCESS;
            w_cnt_nxt   = WAIT_LD;
            w_rdy_nxt   = RDY_LD;
            w_err_nxt   = RDY_LD && w_in_oor;
            w_rd_ld     = RDY_LD;
            w_rd_zero   = apb.PWRITE || w_in_oor;
            w_rd_idx    = apb.PADDR[IDX_W-1:0];
            w_rd_clr    = !RDY_LD;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= w_rdy_nxt;
            r_err   <= w_err_nxt;
            if (w_take) begin
                r_idx   <= apb.PADDR[IDX_W-1:0];
                r_write <= apb.PWRITE;
                r_oor   <= w_in_oor;
                r_wdat  <= apb.PWDATA;
            end
        end
    end

    apb_slave_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_wr_vld  (w_wr_vld),
        .i_wr_idx  (r_idx),
        .i_wr_dat  (r_wdat),
        .i_rd_ld   (w_rd_ld),
        .i_rd_zero (w_rd_zero),
        .i_rd_clr  (w_rd_clr),
        .i_rd_idx  (w_rd_idx),
        .o_rd_dat  (w_rd_dat)
    );

    assign apb.PREADY  = r_rdy;
    assign apb.PSLVERR = r_err;
    assign apb.PRDATA  = w_rd_dat;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: a 2-wait instance and a 0-wait instance sharing one APB driver.
module tb_apb_wait_slave;

    localparam int WAIT_W = 2;
    localparam int DEPTH  = 64;

    logic       pclk;
    logic       presetn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    bit         sel_z;

    logic       rdy, err;
    logic [7:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mdl_w [DEPTH];
    logic [7:0] mdl_z [DEPTH];

    logic [7:0] out_rdata;
    logic       out_err;
    int         out_waits;
    bit         out_clean;

    apb_wait_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_w ();
    apb_wait_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_z ();

    assign if_w.PSEL    = psel && !sel_z;
    assign if_w.PENABLE = penable;
    assign if_w.PWRITE  = pwrite;
    assign if_w.PADDR   = paddr;
    assign if_w.PWDATA  = pwdata;
    assign if_z.PSEL    = psel && sel_z;
    assign if_z.PENABLE = penable;
    assign if_z.PWRITE  = pwrite;
    assign if_z.PADDR   = paddr;
    assign if_z.PWDATA  = pwdata;

    assign rdy   = sel_z ? if_z.PREADY  : if_w.PREADY;
    assign err   = sel_z ? if_z.PSLVERR : if_w.PSLVERR;
    assign rdata = sel_z ? if_z.PRDATA  : if_w.PRDATA;

    apb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_W)) dut (
        .PCLK(pclk), .PRESETn(presetn), .apb(if_w)
    );

    apb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .PCLK(pclk), .PRESETn(presetn), .apb(if_z)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: an access returns stored data for in-range reads, errors for addr >= DEPTH,
    // and updates storage only for in-range writes.
    task automatic model_xfer(input bit z, input bit wr, input logic [7:0] addr,
                              input logic [7:0] data, output logic [7:0] e_rdata,
                              output logic e_err);
        e_err   = (int'(addr) >= DEPTH);
        e_rdata = 8'h00;
        if (!e_err) begin
            if (wr) begin
                if (z) mdl_z[int'(addr)] = data;
                else   mdl_w[int'(addr)] = data;
            end else begin
                e_rdata = z ? mdl_z[int'(addr)] : mdl_w[int'(addr)];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_w[i] = 8'h00;
            mdl_z[i] = 8'h00;
        end
    endtask

    // Called at posedge+1: setup now, access next cycle, then wait for PREADY.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input bit stop_at_ready);
        bit done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        out_clean = 1'b1;
        out_waits = 0;
        @(negedge pclk);
        if (rdy !== 1'b0 || err !== 1'b0 || rdata !== 8'h00) out_clean = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        done = 1'b0;
        while (!done) begin
            @(negedge pclk);
            if (rdy === 1'b1) begin
                done = 1'b1;
            end else begin
                if (err !== 1'b0 || rdata !== 8'h00) out_clean = 1'b0;
                out_waits++;
                if (out_waits > 40) done = 1'b1;
                else begin
                    @(posedge pclk); #1;
                end
            end
        end
        out_rdata = rdata;
        out_err   = err;
        if (!stop_at_ready) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] e_rd;
        logic       e_er;
        presetn = 1'b1;
        #2 presetn = 1'b0;
        #1;
        n_checks++; if (rdy !== 1'b0) $display("FAIL reset_pready: got %b want 0", rdy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_pslverr: got %b want 0", err); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL reset_prdata: got %h want 00", rdata); else n_pass++;
        model_clear();
        @(posedge pclk); #1;
        presetn = 1'b1;

        model_xfer(0, 1, 8'h07, 8'h21, e_rd, e_er);
        xfer(1, 8'h07, 8'h21, 0);
        model_xfer(0, 0, 8'h07, 8'h00, e_rd, e_er);
        xfer(0, 8'h07, 8'h00, 1);
        n_checks++; if (out_rdata !== e_rd) $display("FAIL reset_preread: got %h want %h", out_rdata, e_rd); else n_pass++;
        #2 presetn = 1'b0;
        #1;
        n_checks++; if (rdy !== 1'b0) $display("FAIL reset_mid_pready: got %b want 0", rdy); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL reset_mid_prdata: got %h want 00", rdata); else n_pass++;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        model_clear();

        xfer(0, 8'h45, 8'h00, 1);
        n_checks++; if (out_err !== 1'b1) $display("FAIL reset_pre_err: got %b want 1", out_err); else n_pass++;
        #2 presetn = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_mid_pslverr: got %b want 0", err); else n_pass++;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;

        model_xfer(0, 0, 8'h07, 8'h00, e_rd, e_er);
        xfer(0, 8'h07, 8'h00, 0);
        n_checks++; if (out_rdata !== 8'h00) $display("FAIL reset_mem_clear: got %h want 00", out_rdata); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [7:0] e_rd;
        logic       e_er;
        model_xfer(0, 1, 8'h05, 8'h0A, e_rd, e_er);
        xfer(1, 8'h05, 8'h0A, 0);
        n_checks++; if (out_waits !== WAIT_W) $display("FAIL wait_count: got %0d want %0d", out_waits, WAIT_W); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL wait_wr_err: got %b want 0", out_err); else n_pass++;
        n_checks++; if (out_clean !== 1'b1) $display("FAIL wait_early_outputs: got %b want 1", out_clean); else n_pass++;
        model_xfer(0, 0, 8'h05, 8'h00, e_rd, e_er);
        xfer(0, 8'h05, 8'h00, 0);
        n_checks++; if (out_rdata !== 8'h0A) $display("FAIL wait_readback: got %h want 0a", out_rdata); else n_pass++;
        n_checks++; if (out_waits !== WAIT_W) $display("FAIL wait_rd_count: got %0d want %0d", out_waits, WAIT_W); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_rd;
        logic       e_er;
        for (int i = 0; i < 8; i++) begin
            model_xfer(0, 1, 8'(i), 8'(2 * i), e_rd, e_er);
            xfer(1, 8'(i), 8'(2 * i), 0);
            n_checks++; if (out_waits !== WAIT_W) $display("FAIL burst_wr_wait[%0d]: got %0d want %0d", i, out_waits, WAIT_W); else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            model_xfer(0, 0, 8'(i), 8'h00, e_rd, e_er);
            xfer(0, 8'(i), 8'h00, 0);
            n_checks++; if (out_rdata !== e_rd) $display("FAIL burst_rd[%0d]: got %h want %h", i, out_rdata, e_rd); else n_pass++;
        end
    endtask

    task automatic test_error();
        logic [7:0] e_rd;
        logic       e_er;
        model_xfer(0, 1, 8'h40, 8'h55, e_rd, e_er);
        xfer(1, 8'h40, 8'h55, 0);
        n_checks++; if (out_err !== 1'b1) $display("FAIL err_wr_pslverr: got %b want 1", out_err); else n_pass++;
        model_xfer(0, 0, 8'h40, 8'h00, e_rd, e_er);
        xfer(0, 8'h40, 8'h00, 0);
        n_checks++; if (out_err !== 1'b1) $display("FAIL err_rd_pslverr: got %b want 1", out_err); else n_pass++;
        n_checks++; if (out_rdata !== 8'h00) $display("FAIL err_rd_prdata: got %h want 00", out_rdata); else n_pass++;
        for (int a = 0; a < DEPTH; a++) begin
            model_xfer(0, 0, 8'(a), 8'h00, e_rd, e_er);
            xfer(0, 8'(a), 8'h00, 0);
            n_checks++; if (out_rdata !== e_rd || out_err !== 1'b0) $display("FAIL err_mem_intact[%0d]: got %h/%b want %h/0", a, out_rdata, out_err, e_rd); else n_pass++;
        end
    endtask

    task automatic test_abort();
        bit seen;
        logic [7:0] e_rd;
        logic       e_er;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hAB;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (rdy !== 1'b0) seen = 1'b1;
        end
        @(posedge pclk); #1;
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_pready: got %b want 0", seen); else n_pass++;
        model_xfer(0, 0, 8'h10, 8'h00, e_rd, e_er);
        xfer(0, 8'h10, 8'h00, 0);
        n_checks++; if (out_rdata !== 8'h00) $display("FAIL abort_mem: got %h want 00", out_rdata); else n_pass++;

        // PENABLE without a setup phase must not start an access.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h12; pwdata = 8'h99;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (rdy !== 1'b0) seen = 1'b1;
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        n_checks++; if (seen !== 1'b0) $display("FAIL idle_penable_pready: got %b want 0", seen); else n_pass++;
    endtask

    task automatic test_resetup();
        logic [7:0] e_rd;
        logic       e_er;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h11; pwdata = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        model_xfer(0, 0, 8'h11, 8'h00, e_rd, e_er);
        xfer(0, 8'h11, 8'h00, 0);
        n_checks++; if (out_rdata !== e_rd) $display("FAIL resetup_dropped_wr: got %h want %h", out_rdata, e_rd); else n_pass++;
        n_checks++; if (out_waits !== WAIT_W) $display("FAIL resetup_wait: got %0d want %0d", out_waits, WAIT_W); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [7:0] e_rd;
        logic       e_er;
        sel_z = 1'b1;
        model_xfer(1, 1, 8'h03, 8'h33, e_rd, e_er);
        xfer(1, 8'h03, 8'h33, 0);
        n_checks++; if (out_waits !== 0) $display("FAIL zw_wr_wait: got %0d want 0", out_waits); else n_pass++;
        model_xfer(1, 0, 8'h03, 8'h00, e_rd, e_er);
        xfer(0, 8'h03, 8'h00, 0);
        n_checks++; if (out_waits !== 0) $display("FAIL zw_rd_wait: got %0d want 0", out_waits); else n_pass++;
        n_checks++; if (out_rdata !== 8'h33) $display("FAIL zw_rd_data: got %h want 33", out_rdata); else n_pass++;
        n_checks++; if (out_clean !== 1'b1) $display("FAIL zw_setup_outputs: got %b want 1", out_clean); else n_pass++;
        sel_z = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] e_rd, a, d;
        logic       e_er;
        bit         wr;
        int         e_wait;
        for (int i = 0; i < 200; i++) begin
            sel_z = ($urandom_range(0, 2) == 0);
            wr    = $urandom_range(0, 1) == 1;
            a     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            d     = 8'($urandom);
            e_wait = sel_z ? 0 : WAIT_W;
            model_xfer(sel_z, wr, a, d, e_rd, e_er);
            xfer(wr, a, d, 0);
            n_checks++; if (out_rdata !== e_rd) $display("FAIL rnd_rdata[%0d]: got %h want %h", i, out_rdata, e_rd); else n_pass++;
            n_checks++; if (out_err !== e_er) $display("FAIL rnd_err[%0d]: got %b want %b", i, out_err, e_er); else n_pass++;
            n_checks++; if (out_waits !== e_wait) $display("FAIL rnd_wait[%0d]: got %0d want %0d", i, out_waits, e_wait); else n_pass++;
            n_checks++; if (out_clean !== 1'b1) $display("FAIL rnd_early_outputs[%0d]: got %b want 1", i, out_clean); else n_pass++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end
        sel_z = 1'b0;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        sel_z = 1'b0;
        presetn = 1'b1;
        model_clear();
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_abort();
        test_resetup();
        test_zero_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
